// File: rtl/pen_matrix_ctrl_pkg.sv
// Shared definitions for the light-pen LED matrix controller: colour codes,
// FSM state encoding and small elaboration-time helpers.
package pen_matrix_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_PROBE = 2'd2
  } state_t;

  localparam logic [1:0] COL_OFF   = 2'b00;
  localparam logic [1:0] COL_RED   = 2'b01;
  localparam logic [1:0] COL_GREEN = 2'b10;
  localparam logic [1:0] COL_YEL   = 2'b11;

  localparam int RED_BIT   = 0;
  localparam int GREEN_BIT = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pen_matrix_ctrl_pen_sync.sv
// Light-pen input conditioning: two-flop synchroniser on the raw photodetector
// followed by a sample-window qualifier that produces the pen_hit indication.
module pen_sync (
  input  logic clk,
  input  logic rst,
  input  logic pen_i,
  input  logic win_i,
  output logic pen_hit
);

  logic pen_p0;
  logic pen_p1;

  // stage p0/p1: metastability filter on the asynchronous detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pen_p0 <= 1'b0;
      pen_p1 <= 1'b0;
    end else begin
      pen_p0 <= pen_i;
      pen_p1 <= pen_p0;
    end
  end

  assign pen_hit = pen_p1 & win_i;

endmodule

// File: rtl/pen_matrix_ctrl.sv
// Bicolour LED matrix driver with framebuffer, row multiplexing and light-pen probe frames.
// Optional brightness PWM on display rows is compiled in with `define MATRIX_PWM_EN.
module pen_matrix_ctrl
  import pen_matrix_ctrl_pkg::*;
#(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int SCAN_DIV    = 1000,
  parameter int PROBE_DIV   = 64,
  parameter int PROBE_EVERY = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    probe_en,
  input  logic                    draw_en,
  input  logic [1:0]              draw_color,
  input  logic                    pen_i,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [$clog2(COLS)-1:0] wr_col,
  input  logic [1:0]              wr_data,
  input  logic                    clr,
  input  logic [2:0]              bright,
  output logic [ROWS-1:0]         row_o,
  output logic [COLS-1:0]         col_r_o,
  output logic [COLS-1:0]         col_g_o,
  output logic                    pen_valid,
  output logic [$clog2(ROWS)-1:0] pen_row,
  output logic [$clog2(COLS)-1:0] pen_col
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(max_int(SCAN_DIV, PROBE_DIV) + 1);
  localparam int FW = $clog2(PROBE_EVERY + 1);

  localparam logic [DW-1:0] SCAN_END   = DW'(SCAN_DIV);
  localparam logic [DW-1:0] PROBE_END  = DW'(PROBE_DIV);
  localparam logic [DW-1:0] WIN_START  = DW'(PROBE_DIV / 2 + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(PROBE_EVERY - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [RW:0]   ROWS_L     = (RW + 1)'(ROWS);
  localparam logic [CW:0]   COLS_L     = (CW + 1)'(COLS);

  state_t         state;
  logic [RW-1:0]  row_idx;
  logic [CW-1:0]  col_idx;
  logic [DW-1:0]  div_cnt;
  logic [FW-1:0]  frame_cnt;
  logic [1:0]     fb [ROWS][COLS];
  logic [COLS-1:0] fb_row_r;
  logic [COLS-1:0] fb_row_g;
  logic           probe_win;
  logic           pen_hit;
  logic           draw_hit;
  logic           wr_ok;

`ifdef MATRIX_PWM_EN
  logic [DW-1:0]  pwm_lim;

  function automatic logic [DW-1:0] pwm_limit(input logic [2:0] b);
    return DW'(((int'(b) + 1) * SCAN_DIV) / 8);
  endfunction
`else
  logic unused_bright;
  assign unused_bright = ^bright;
`endif

  function automatic logic [ROWS-1:0] row_sel(input logic [RW-1:0] r);
    return ~(ROWS'(1) << r);
  endfunction

  function automatic logic [COLS-1:0] col_sel(input logic [CW-1:0] c);
    return COLS'(1) << c;
  endfunction

  always_comb begin
    fb_row_r = '0;
    fb_row_g = '0;
    for (int c = 0; c < COLS; c++) begin
      fb_row_r[c] = fb[row_idx][c][RED_BIT];
      fb_row_g[c] = fb[row_idx][c][GREEN_BIT];
    end
  end

  // Only the second half of each lit pixel is sampled so the detector has settled.
  assign probe_win = (state == ST_PROBE) && (div_cnt >= WIN_START);
  assign draw_hit  = pen_hit && enable && draw_en;
  assign wr_ok     = ({1'b0, wr_row} < ROWS_L) && ({1'b0, wr_col} < COLS_L);

  pen_sync u_pen_sync (
    .clk     (clk),
    .rst     (rst),
    .pen_i   (pen_i),
    .win_i   (probe_win),
    .pen_hit (pen_hit)
  );

  // Each row or pixel dwell is one blank cycle (div_cnt==0) followed by the lit cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      row_idx   <= '0;
      col_idx   <= '0;
      div_cnt   <= '0;
      frame_cnt <= '0;
      row_o     <= '1;
      col_r_o   <= '0;
      col_g_o   <= '0;
      pen_valid <= 1'b0;
      pen_row   <= '0;
      pen_col   <= '0;
`ifdef MATRIX_PWM_EN
      pwm_lim   <= '0;
`endif
    end else begin
      pen_valid <= 1'b0;
      if (!enable) begin
        state   <= ST_IDLE;
        row_idx <= '0;
        col_idx <= '0;
        div_cnt <= '0;
        row_o   <= '1;
        col_r_o <= '0;
        col_g_o <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_SCAN;
            row_idx <= '0;
            col_idx <= '0;
            div_cnt <= '0;
            row_o   <= '1;
            col_r_o <= '0;
            col_g_o <= '0;
          end

          ST_SCAN: begin
            if (div_cnt == SCAN_END) begin
              div_cnt <= '0;
              row_o   <= '1;
              col_r_o <= '0;
              col_g_o <= '0;
              if (row_idx == ROW_LAST) begin
                row_idx <= '0;
                if (frame_cnt == FRAME_LAST) begin
                  frame_cnt <= '0;
                  if (probe_en) begin
                    state   <= ST_PROBE;
                    col_idx <= '0;
                  end
                end else begin
                  frame_cnt <= frame_cnt + 1'b1;
                end
              end else begin
                row_idx <= row_idx + 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
              row_o   <= row_sel(row_idx);
              // Row data is latched once per dwell so writes land at the next refresh.
              if (div_cnt == '0) begin
`ifdef MATRIX_PWM_EN
                pwm_lim <= pwm_limit(bright);
                col_r_o <= (pwm_limit(bright) == '0) ? '0 : fb_row_r;
                col_g_o <= (pwm_limit(bright) == '0) ? '0 : fb_row_g;
`else
                col_r_o <= fb_row_r;
                col_g_o <= fb_row_g;
`endif
              end
`ifdef MATRIX_PWM_EN
              else if (div_cnt >= pwm_lim) begin
                col_r_o <= '0;
                col_g_o <= '0;
              end
`endif
            end
          end

          ST_PROBE: begin
            if (pen_hit) begin
              pen_valid <= 1'b1;
              pen_row   <= row_idx;
              pen_col   <= col_idx;
              state     <= ST_SCAN;
              row_idx   <= '0;
              col_idx   <= '0;
              div_cnt   <= '0;
              row_o     <= '1;
              col_r_o   <= '0;
              col_g_o   <= '0;
            end else if (div_cnt == PROBE_END) begin
              div_cnt <= '0;
              row_o   <= '1;
              col_r_o <= '0;
              col_g_o <= '0;
              if (col_idx == COL_LAST) begin
                col_idx <= '0;
                if (row_idx == ROW_LAST) begin
                  row_idx <= '0;
                  state   <= ST_SCAN;
                end else begin
                  row_idx <= row_idx + 1'b1;
                end
              end else begin
                col_idx <= col_idx + 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
              row_o   <= row_sel(row_idx);
              col_r_o <= '0;
              col_g_o <= col_sel(col_idx);
            end
          end

          default: begin
            state   <= ST_IDLE;
            row_o   <= '1;
            col_r_o <= '0;
            col_g_o <= '0;
          end
        endcase
      end
    end
  end

  // Later statements win: host write overrides a pen draw on the same pixel; clr beats both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          fb[r][c] <= COL_OFF;
    end else if (clr) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          fb[r][c] <= COL_OFF;
    end else begin
      if (draw_hit)
        fb[row_idx][col_idx] <= draw_color;
      if (wr_en && wr_ok)
        fb[wr_row][wr_col] <= wr_data;
    end
  end

endmodule
